// File: rtl/cpu16_opctl.sv
// cpu16_opctl: multicycle operand/control stage feeding cpu16_alu, with 8x16 register file.
// Optional ZF/NF flag outputs are enabled by defining CPU16_OPCTL_FLAGS_EN.
module cpu16_opctl #(
    parameter bit          R0_ZERO = 1'b1,
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        ivalid,
    output logic        iready,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [3:0]  icnt,
    input  logic [15:0] alu_out,
    output logic        done,
    output logic        ill,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
`ifdef CPU16_OPCTL_FLAGS_EN
    ,
    output logic        zf,
    output logic        nf
`endif
);
    typedef enum logic [1:0] {IDLE, OPRD, EXEC, WB} state_t;
    state_t      state;
    logic [15:0] ir, res;
    logic [15:0] regs [8];
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] rs_val, rt_val;
    assign op = ir[15:12];
    assign rd = ir[11:9];
    assign rs = ir[8:6];
    assign rt = ir[5:3];
    // R0 reads as zero when hardwired, regardless of its stored value
    assign rs_val   = (R0_ZERO && rs == 3'd0) ? 16'h0000 : regs[rs];
    assign rt_val   = (R0_ZERO && rt == 3'd0) ? 16'h0000 : regs[rt];
    assign dbg_data = (R0_ZERO && dbg_addr == 3'd0) ? 16'h0000 : regs[dbg_addr];

    // control FSM, operand/result registers and register file with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= '0;
            res    <= '0;
            a      <= '0;
            b      <= '0;
            icnt   <= '0;
            iready <= 1'b1;
            done   <= 1'b0;
            ill    <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= RST_VAL;
`ifdef CPU16_OPCTL_FLAGS_EN
            zf     <= 1'b0;
            nf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            ill  <= 1'b0;
            case (state)
                IDLE: if (ivalid) begin
                    ir     <= instr;
                    iready <= 1'b0;
                    ill    <= instr[15:12] > 4'd5;
                    state  <= OPRD;
                end
                OPRD: begin
                    if (op >= 4'd1 && op <= 4'd4) begin
                        a     <= rs_val;
                        b     <= rt_val;
                        icnt  <= 4'b0001 << (op - 4'd1);
                        state <= EXEC;
                    end else if (op == 4'd5) begin
                        res   <= {7'b0, ir[8:0]};
                        done  <= 1'b1;
                        state <= WB;
                    end else begin
                        iready <= 1'b1;
                        state  <= IDLE;
                    end
                end
                EXEC: begin
                    res   <= alu_out;
                    icnt  <= '0;
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    if (!(R0_ZERO && rd == 3'd0)) regs[rd] <= res;
`ifdef CPU16_OPCTL_FLAGS_EN
                    zf <= res == 16'h0000;
                    nf <= res[15];
`endif
                    iready <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu16_opctl.sv
// tb_cpu16_opctl: directed self-checking bench for cpu16_opctl with a behavioural ALU.
module tb_cpu16_opctl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        ivalid;
    logic        iready;
    logic [15:0] a, b, alu_out, dbg_data;
    logic [3:0]  icnt;
    logic        done, ill;
    logic [2:0]  dbg_addr;
`ifdef CPU16_OPCTL_FLAGS_EN
    logic        zf, nf;
`endif
    int          n = 0, npass = 0, nfail = 0, dcount = 0;
    logic [15:0] exp_r [8];
    logic [15:0] prog [4];
    int          plen [4];

    cpu16_opctl dut (
        .clk(clk), .rst(rst), .instr(instr), .ivalid(ivalid), .iready(iready),
        .a(a), .b(b), .icnt(icnt), .alu_out(alu_out), .done(done), .ill(ill),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef CPU16_OPCTL_FLAGS_EN
        , .zf(zf), .nf(nf)
`endif
    );

    always #5 clk = ~clk;

    // behavioural cpu16_alu
    always_comb
        alu_out = icnt == 4'b0001 ? a + b :
                  icnt == 4'b0010 ? a - b :
                  icnt == 4'b0100 ? a & b :
                  icnt == 4'b1000 ? a | b : 16'h0000;

    always @(posedge clk) if (done) dcount++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), dbg_data, exp_r[i]);
        end
    endtask

    task automatic run_ldi(input logic [2:0] rd, input logic [8:0] imm);
        instr  = {4'h5, rd, imm};
        ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        chk("ldi_oprd_iready", 16'(iready), 16'd0);
        chk("ldi_oprd_done", 16'(done), 16'd0);
        step();
        chk("ldi_wb_done", 16'(done), 16'd1);
        step();
        if (rd != 3'd0) exp_r[rd] = {7'b0, imm};
        chk("ldi_idle_iready", 16'(iready), 16'd1);
        dbg_addr = rd;
        #1;
        chk("ldi_dbg", dbg_data, exp_r[rd]);
    endtask

    task automatic run_alu(input logic [15:0] ins, input logic [15:0] ea, input logic [15:0] eb,
                           input logic [3:0] eic, input logic [15:0] er);
        instr  = ins;
        ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        chk("alu_oprd_iready", 16'(iready), 16'd0);
        step();
        chk("exec_a", a, ea);
        chk("exec_b", b, eb);
        chk("exec_icnt", 16'(icnt), 16'(eic));
        chk("exec_done", 16'(done), 16'd0);
        step();
        chk("wb_done", 16'(done), 16'd1);
        chk("wb_icnt", 16'(icnt), 16'd0);
        step();
        if (ins[11:9] != 3'd0) exp_r[ins[11:9]] = er;
        chk("idle_done", 16'(done), 16'd0);
        chk("idle_iready", 16'(iready), 16'd1);
        dbg_addr = ins[11:9];
        #1;
        chk("alu_dbg", dbg_data, exp_r[ins[11:9]]);
`ifdef CPU16_OPCTL_FLAGS_EN
        chk("zf", 16'(zf), 16'(er == 16'h0000));
        chk("nf", 16'(nf), 16'(er[15]));
`endif
    endtask

    initial begin
        int cnt, d0;
        for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
        rst = 1'b1; ivalid = 1'b0; instr = '0; dbg_addr = '0;
        #1;
        chk("rst_iready", 16'(iready), 16'd1);
        chk("rst_a", a, 16'h0);
        chk("rst_b", b, 16'h0);
        chk("rst_icnt", 16'(icnt), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_ill", 16'(ill), 16'h0);
        step(); step();
        rst = 1'b0;
        step();
        chk_regs("rst");
        run_ldi(3'd1, 9'd1);
        run_ldi(3'd2, 9'd10);
        run_alu({4'h1, 3'd3, 3'd1, 3'd2, 3'd0}, 16'd1, 16'd10, 4'b0001, 16'h000B);
        run_alu({4'h2, 3'd4, 3'd2, 3'd1, 3'd0}, 16'd10, 16'd1, 4'b0010, 16'h0009);
        run_alu({4'h2, 3'd5, 3'd1, 3'd2, 3'd0}, 16'd1, 16'd10, 4'b0010, 16'hFFF7);
        run_ldi(3'd6, 9'h00C);
        run_ldi(3'd7, 9'h00A);
        run_alu({4'h3, 3'd1, 3'd6, 3'd7, 3'd0}, 16'h000C, 16'h000A, 4'b0100, 16'h0008);
        run_alu({4'h4, 3'd2, 3'd6, 3'd7, 3'd0}, 16'h000C, 16'h000A, 4'b1000, 16'h000E);
        run_alu({4'h1, 3'd0, 3'd2, 3'd2, 3'd0}, 16'h000E, 16'h000E, 4'b0001, 16'h001C);
        run_alu({4'h2, 3'd4, 3'd4, 3'd4, 3'd0}, 16'h0009, 16'h0009, 4'b0010, 16'h0000);
        // illegal opcode: ILL pulse, no DONE, file unchanged
        instr = 16'hF123; ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        chk("ill_pulse", 16'(ill), 16'd1);
        chk("ill_done", 16'(done), 16'd0);
        step();
        chk("ill_clear", 16'(ill), 16'd0);
        chk("ill_done2", 16'(done), 16'd0);
        chk("ill_iready", 16'(iready), 16'd1);
        chk_regs("ill");
        // back-to-back with ivalid held high
        prog[0] = {4'h5, 3'd1, 9'd3};                 plen[0] = 2;
        prog[1] = {4'h5, 3'd2, 9'd5};                 plen[1] = 2;
        prog[2] = {4'h1, 3'd3, 3'd1, 3'd2, 3'd0};     plen[2] = 3;
        prog[3] = {4'h2, 3'd4, 3'd3, 3'd1, 3'd0};     plen[3] = 3;
        d0 = dcount;
        ivalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = prog[k];
            chk($sformatf("b2b_ready%0d", k), 16'(iready), 16'd1);
            step();
            cnt = 0;
            while (!iready && cnt < 10) begin
                cnt++;
                step();
            end
            chk($sformatf("b2b_busy%0d", k), 16'(cnt), 16'(plen[k]));
        end
        ivalid = 1'b0;
        step();
        chk("b2b_dones", 16'(dcount - d0), 16'd4);
        exp_r[1] = 16'd3; exp_r[2] = 16'd5; exp_r[3] = 16'd8; exp_r[4] = 16'd5;
        chk_regs("b2b");
        // reset during EXEC aborts the write
        instr = {4'h1, 3'd3, 3'd2, 3'd2, 3'd0}; ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        step();
        chk("abort_exec_icnt", 16'(icnt), 16'b0001);
        rst = 1'b1;
        #1;
        chk("abort_icnt", 16'(icnt), 16'd0);
        chk("abort_iready", 16'(iready), 16'd1);
        chk("abort_a", a, 16'h0);
        for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
        chk_regs("abort");
        step();
        rst = 1'b0;
        step(); step(); step();
        chk("post_done", 16'(done), 16'd0);
        chk("post_iready", 16'(iready), 16'd1);
        chk_regs("post");
        $display("%0d/%0d checks passed", npass, n);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
